// File: rtl/fdd_track_loader.sv
// -----------------------------------------------------------------------------
// fdd_track_loader
//
// Watches the CPU-side drive/track/slot selection for up to NUM_DRIVES floppy
// drives. When a strobed selection differs from the one currently buffered,
// it computes the first SD-card LBA of that track plus the byte offset of the
// track data inside that first sector, then issues one read request to the
// SD block reader. A per-request timeout aborts reads that never complete.
//
// Optional feature (macro FDD_TRACK_LOADER_RETRY_EN):
//   defined   - a timeout re-issues the same request up to RETRIES times
//               before err is raised.
//   undefined - the first timeout raises err; no retry logic exists.
//
// Ports:
//   clk, nreset   system clock, asynchronous active-low reset
//   cpu_stb       one-clk strobe qualifying drive_sel/track/slot_bus
//   card_ready    SD card initialised
//   drive_sel     selected drive
//   track         head track of the selected drive
//   slot_bus      slot index of drive n at [n*SLOT_W +: SLOT_W]
//   rd_ready      SD reader idle (1) / busy (0)
//   rd_req        read request to the SD reader
//   rd_lba        start LBA of the track
//   byte_skip     offset of the track data within the first sector
//   loaded        buffer holds the currently selected track
//   busy          load in progress
//   err           last load timed out
// -----------------------------------------------------------------------------
module fdd_track_loader #(
  parameter int          NUM_DRIVES   = 2,
  parameter int          DRV_W        = 1,
  parameter int          TRACK_W      = 8,
  parameter int          SLOT_W       = 8,
  parameter int unsigned TRACK_BYTES  = 12928,
  parameter int unsigned SLOT_SECTORS = 4040,
  parameter int unsigned BASE_LBA     = 0,
  parameter int          TIMEOUT_W    = 24,
  parameter int          RETRIES      = 3
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         cpu_stb,
  input  logic                         card_ready,
  input  logic [DRV_W-1:0]             drive_sel,
  input  logic [TRACK_W-1:0]           track,
  input  logic [NUM_DRIVES*SLOT_W-1:0] slot_bus,
  input  logic                         rd_ready,
  output logic                         rd_req,
  output logic [31:0]                  rd_lba,
  output logic [8:0]                   byte_skip,
  output logic                         loaded,
  output logic                         busy,
  output logic                         err
);

  if (NUM_DRIVES < 1 || (2 ** DRV_W) < NUM_DRIVES || RETRIES < 0) begin : g_bad_params
    $error("fdd_track_loader: inconsistent NUM_DRIVES/DRV_W/RETRIES");
  end

  typedef enum logic [2:0] {
    S_WAIT_CARD, S_IDLE, S_CALC1, S_CALC2, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [TRACK_W-1:0]   r_cur_track;
  logic [DRV_W-1:0]     r_cur_drive;
  logic [SLOT_W-1:0]    r_cur_slot;
  logic [31:0]          r_off;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 r_rd_req;
  logic [31:0]          r_rd_lba;
  logic [8:0]           r_byte_skip;
  logic                 r_loaded, r_busy, r_err;

  logic [SLOT_W-1:0]    w_slot_sel;
  logic                 w_drv_ok, w_change, w_start;
  logic                 w_timeout, w_retry, w_fail, w_rearm;

  // Slot of the currently addressed drive.
  // NOTE: every signal driven from always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    w_slot_sel = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (drive_sel == DRV_W'(i)) w_slot_sel = slot_bus[i*SLOT_W +: SLOT_W];
    end
  end

  assign w_drv_ok  = 32'(drive_sel) < 32'(NUM_DRIVES);
  assign w_change  = (track != r_cur_track) || (drive_sel != r_cur_drive) ||
                     (w_slot_sel != r_cur_slot);
  assign w_start   = (r_state == S_IDLE) && cpu_stb && w_drv_ok && w_change;
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) && (&r_tmo);
  assign w_fail    = w_timeout && !w_retry;
  assign w_rearm   = w_timeout && w_retry;

`ifdef FDD_TRACK_LOADER_RETRY_EN
  localparam int RTY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  logic [RTY_W-1:0] r_retry;

  assign w_retry = 32'(r_retry) < 32'(RETRIES);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)       r_retry <= '0;
    else if (w_start)  r_retry <= '0;
    else if (w_rearm)  r_retry <= r_retry + 1'b1;
  end
`else
  assign w_retry = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_WAIT_CARD;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_WAIT_CARD: if (card_ready) w_state_nxt = S_IDLE;
      S_IDLE:      if (w_start)    w_state_nxt = S_CALC1;
      S_CALC1:                     w_state_nxt = S_CALC2;
      S_CALC2:                     w_state_nxt = S_REQ;
      S_REQ: begin
        if      (w_fail)    w_state_nxt = S_IDLE;
        else if (w_rearm)   w_state_nxt = S_REQ;
        else if (!rd_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if      (w_fail)   w_state_nxt = S_IDLE;
        else if (w_rearm)  w_state_nxt = S_REQ;
        else if (rd_ready) w_state_nxt = S_DONE;
      end
      S_DONE:              w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_WAIT_CARD;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cur_track <= '1;
      r_cur_drive <= '1;
      r_cur_slot  <= '1;
      r_off       <= '0;
      r_tmo       <= '0;
      r_rd_req    <= 1'b0;
      r_rd_lba    <= 32'hFFFF_FFFF;
      r_byte_skip <= '0;
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cur_track <= track;
            r_cur_drive <= drive_sel;
            r_cur_slot  <= w_slot_sel;
            r_loaded    <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        S_CALC1: r_off <= 32'(r_cur_track) * TRACK_BYTES;
        S_CALC2: begin
          r_rd_lba    <= BASE_LBA + 32'(r_cur_slot) * SLOT_SECTORS + {9'd0, r_off[31:9]};
          r_byte_skip <= r_off[8:0];
          r_rd_req    <= 1'b1;
          r_tmo       <= '0;
        end
        S_REQ, S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_fail) begin
            // Forcing cur_track re-arms the change detector so the same
            // selection strobed again starts a fresh load.
            r_rd_req    <= 1'b0;
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_loaded    <= 1'b0;
            r_cur_track <= '1;
          end else if (w_rearm) begin
            r_rd_req <= 1'b1;
            r_tmo    <= '0;
          end else if ((r_state == S_REQ) && !rd_ready) begin
            r_rd_req <= 1'b0;
          end else if ((r_state == S_WAIT) && rd_ready) begin
            r_loaded <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_req    = r_rd_req;
  assign rd_lba    = r_rd_lba;
  assign byte_skip = r_byte_skip;
  assign loaded    = r_loaded;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_fdd_track_loader.sv
// -----------------------------------------------------------------------------
// tb_fdd_track_loader
//
// Self-checking bench for fdd_track_loader (3 drives, 8-bit timeout counter).
// Table of directed loads, hand-written multi-cycle sequences (selection change
// while busy, timeout, reset mid-load) and a randomized phase checked against
// an arithmetic reference model of the selection/LBA rules.
// -----------------------------------------------------------------------------
module tb_fdd_track_loader;

  localparam int          ND   = 3;
  localparam int          DW   = 2;
  localparam int          TW   = 8;
  localparam int unsigned TB_B = 12928;
  localparam int unsigned SS   = 4040;
  localparam int unsigned BASE = 0;
`ifdef FDD_TRACK_LOADER_RETRY_EN
  localparam int TRIES = 4;
`else
  localparam int TRIES = 1;
`endif

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          cpu_stb = 1'b0;
  logic          card_ready = 1'b0;
  logic [DW-1:0] drive_sel = '0;
  logic [7:0]    track = '0;
  logic [23:0]   slot_bus = '0;
  logic          rd_ready = 1'b1;
  logic          rd_req;
  logic [31:0]   rd_lba;
  logic [8:0]    byte_skip;
  logic          loaded, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: currently buffered selection.
  logic [7:0]    m_track;
  logic [DW-1:0] m_drive;
  logic [7:0]    m_slot;

  fdd_track_loader #(
    .NUM_DRIVES(ND), .DRV_W(DW), .TRACK_W(8), .SLOT_W(8),
    .TRACK_BYTES(TB_B), .SLOT_SECTORS(SS), .BASE_LBA(BASE),
    .TIMEOUT_W(TW), .RETRIES(3)
  ) dut (
    .clk(clk), .nreset(nreset), .cpu_stb(cpu_stb), .card_ready(card_ready),
    .drive_sel(drive_sel), .track(track), .slot_bus(slot_bus),
    .rd_ready(rd_ready), .rd_req(rd_req), .rd_lba(rd_lba),
    .byte_skip(byte_skip), .loaded(loaded), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] slot_of(input logic [DW-1:0] drv, input logic [23:0] sb);
    return (drv < DW'(ND)) ? sb[drv*8 +: 8] : 8'd0;
  endfunction

  function automatic logic [31:0] ref_off(input logic [7:0] trk);
    return 32'(trk) * TB_B;
  endfunction

  function automatic logic [31:0] ref_lba(input logic [7:0] slot, input logic [7:0] trk);
    return BASE + 32'(slot) * SS + ref_off(trk) / 512;
  endfunction

  function automatic logic [8:0] ref_skip(input logic [7:0] trk);
    return 9'(ref_off(trk) % 512);
  endfunction

  function automatic bit ref_load(input logic [DW-1:0] drv, input logic [7:0] trk,
                                  input logic [23:0] sb);
    if (drv >= DW'(ND)) return 1'b0;
    return (trk != m_track) || (drv != m_drive) || (slot_of(drv, sb) != m_slot);
  endfunction

  task automatic model_reset();
    m_track = '1;
    m_drive = '1;
    m_slot  = '1;
  endtask

  // Strobe a selection; returns whether rd_req rose and after how many clocks.
  task automatic strobe(input logic [DW-1:0] drv, input logic [7:0] trk,
                        input logic [23:0] sb, input bit stop_on_req,
                        output bit seen, output int lat);
    @(negedge clk);
    drive_sel = drv; track = trk; slot_bus = sb; cpu_stb = 1'b1;
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_stb = 1'b0;
      lat++;
      if (rd_req) begin
        seen = 1'b1;
        if (stop_on_req) break;
      end
    end
  endtask

  task automatic run_txn(input logic [DW-1:0] drv, input logic [7:0] trk,
                         input logic [23:0] sb, input bit exp_load,
                         input logic [31:0] exp_lba, input logic [8:0] exp_skip,
                         input int hold, input string tag);
    bit seen;
    int lat;
    strobe(drv, trk, sb, exp_load, seen, lat);
    if (!exp_load) begin
      check({tag, "_no_req"}, 32'(seen), 0);
      check({tag, "_idle_busy"}, 32'(busy), 0);
      return;
    end
    check({tag, "_req_seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, "_latency"}, lat, 3);
    check({tag, "_lba"}, rd_lba, exp_lba);
    check({tag, "_skip"}, 32'(byte_skip), 32'(exp_skip));
    check({tag, "_busy"}, {30'd0, busy, loaded}, 32'b10);
    rd_ready = 1'b0;
    repeat (hold) @(negedge clk);
    check({tag, "_req_drop"}, 32'(rd_req), 0);
    rd_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done"}, {29'd0, loaded, busy, err}, 32'b100);
    m_track = trk; m_drive = drv; m_slot = slot_of(drv, sb);
  endtask

  task automatic model_txn(input logic [DW-1:0] drv, input logic [7:0] trk,
                           input logic [23:0] sb, input int hold, input string tag);
    run_txn(drv, trk, sb, ref_load(drv, trk, sb), ref_lba(slot_of(drv, sb), trk),
            ref_skip(trk), hold, tag);
  endtask

  typedef struct {
    logic [DW-1:0] drv;
    logic [7:0]    trk;
    logic [23:0]   sb;     // {slot2, slot1, slot0}
    bit            load;
    logic [31:0]   lba;
    logic [8:0]    skip;
    int            hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit   seen;
    int   lat, pulses, cyc;
    logic prev;
    logic [DW-1:0] rdrv;
    logic [7:0]    rtrk;
    logic [23:0]   rsb;

    vecs[0] = '{2'd0, 8'd1, {8'd0, 8'd2, 8'd0}, 1'b1, 32'd25,    9'd128, 4};
    vecs[1] = '{2'd1, 8'd3, {8'd0, 8'd2, 8'd0}, 1'b1, 32'd8155,  9'd384, 100};
    vecs[2] = '{2'd1, 8'd3, {8'd0, 8'd2, 8'd0}, 1'b0, 32'd0,     9'd0,   1};
    vecs[3] = '{2'd1, 8'd3, {8'd0, 8'd2, 8'd0}, 1'b0, 32'd0,     9'd0,   1};
    vecs[4] = '{2'd1, 8'd3, {8'd0, 8'd3, 8'd0}, 1'b1, 32'd12195, 9'd384, 7};
    vecs[5] = '{2'd3, 8'd3, {8'd0, 8'd3, 8'd0}, 1'b0, 32'd0,     9'd0,   1};
    vecs[6] = '{2'd2, 8'd0, {8'd1, 8'd3, 8'd0}, 1'b1, 32'd4040,  9'd0,   2};
    vecs[7] = '{2'd0, 8'd1, {8'd1, 8'd3, 8'd0}, 1'b1, 32'd25,    9'd128, 3};

    // Reset values.
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outputs", {28'd0, rd_req, loaded, busy, err}, 0);
    check("rst_lba", rd_lba, 32'hFFFF_FFFF);
    check("rst_skip", 32'(byte_skip), 0);
    nreset = 1'b1;

    // Card not ready: strobes with changing selections are ignored.
    run_txn(2'd0, 8'd1, 24'd0, 1'b0, 0, 0, 1, "nocard_a");
    run_txn(2'd1, 8'd7, 24'd0, 1'b0, 0, 0, 1, "nocard_b");
    card_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table.
    foreach (vecs[i])
      run_txn(vecs[i].drv, vecs[i].trk, vecs[i].sb, vecs[i].load, vecs[i].lba,
              vecs[i].skip, vecs[i].hold, $sformatf("vec%0d", i));

    // Selection change during WAIT is ignored until the load completes.
    strobe(2'd0, 8'd2, {8'd1, 8'd3, 8'd0}, 1'b1, seen, lat);
    check("busychg_req", 32'(seen), 1);
    check("busychg_lba", rd_lba, 32'd50);
    check("busychg_skip", 32'(byte_skip), 256);
    rd_ready = 1'b0;
    repeat (4) @(negedge clk);
    track = 8'd5; cpu_stb = 1'b1;
    @(negedge clk);
    cpu_stb = 1'b0;
    repeat (4) @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    check("busychg_loaded", 32'(loaded), 1);
    check("busychg_lba_hold", rd_lba, 32'd50);
    m_track = 8'd2; m_drive = 2'd0; m_slot = 8'd0;
    run_txn(2'd0, 8'd5, {8'd1, 8'd3, 8'd0}, 1'b1, 32'd126, 9'd128, 5, "trk5");

    // Reader never completes: timeout (with retries when enabled).
    strobe(2'd1, 8'd7, {8'd1, 8'd3, 8'd0}, 1'b1, seen, lat);
    check("tmo_req", 32'(seen), 1);
    rd_ready = 1'b0;
    pulses = 1; prev = 1'b1; cyc = 0;
    while (!err && cyc < 6 * (2 ** TW)) begin
      @(negedge clk);
      cyc++;
      if (rd_req && !prev) pulses++;
      prev = rd_req;
    end
    check("tmo_err", 32'(err), 1);
    check("tmo_pulses", pulses, TRIES);
    check("tmo_status", {30'd0, busy, loaded}, 0);
    check("tmo_min_cycles", 32'(cyc >= TRIES * (2 ** TW - 2)), 1);
    check("tmo_max_cycles", 32'(cyc <= TRIES * (2 ** TW + 4)), 1);
    rd_ready = 1'b1;
    m_track = '1;
    model_txn(2'd1, 8'd7, {8'd1, 8'd3, 8'd0}, 6, "tmo_reload");
    check("tmo_err_clr", 32'(err), 0);

    // Reset asserted during WAIT.
    strobe(2'd2, 8'd9, {8'd1, 8'd3, 8'd0}, 1'b1, seen, lat);
    check("rstw_req", 32'(seen), 1);
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("rstw_outputs", {28'd0, rd_req, loaded, busy, err}, 0);
    check("rstw_lba", rd_lba, 32'hFFFF_FFFF);
    check("rstw_skip", 32'(byte_skip), 0);
    @(negedge clk);
    nreset = 1'b1; rd_ready = 1'b1; card_ready = 1'b0;
    model_reset();
    run_txn(2'd2, 8'd9, {8'd1, 8'd3, 8'd0}, 1'b0, 0, 0, 1, "rstw_nocard");
    card_ready = 1'b1;
    repeat (2) @(negedge clk);
    model_txn(2'd2, 8'd9, {8'd1, 8'd3, 8'd0}, 3, "rstw_reload");

    // Randomized selections against the reference model.
    rsb = {8'd1, 8'd3, 8'd0};
    for (int n = 0; n < 30; n++) begin
      rdrv = DW'($urandom_range(0, 3));
      rtrk = ($urandom_range(0, 2) == 0) ? m_track : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rsb[8*$urandom_range(0, 2) +: 8] = 8'($urandom);
      model_txn(rdrv, rtrk, rsb, $urandom_range(1, 20), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
